// File: rtl/fpu_p.sv
// ---------------------------------------------------------------------------
// fpu_p -- shared types and constants for the FPU complex.
//
// Contents:
//   FPU_32 / FPU_64  : supported operand widths
//   FPU_ARB_NREQ     : default number of requester ports on fpu_arbiter
//   Operation        : operation code passed to the shared FPU core
//   ArbState         : fpu_arbiter FSM states (also exported on its debug port)
//   arb_cnt_width()  : width of the arbiter's busy-cycle counter
// ---------------------------------------------------------------------------
package fpu_p;

  localparam int FPU_32       = 32;
  localparam int FPU_64       = 64;
  localparam int FPU_ARB_NREQ = 4;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2
  } Operation;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } ArbState;

  // The busy counter must be able to hold TIMEOUT and is never narrower than
  // 8 bits, so short timeouts still get a usable counter.
  function automatic int arb_cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/fpu_rr_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_rr_arbiter -- combinational round-robin picker.
//
// Searches the request vector starting at index ptr_i and wrapping around;
// the first set bit wins.
//
// Ports:
//   req_i   [NREQ-1:0]  request vector
//   ptr_i   [IDXW-1:0]  index where the search begins (highest priority)
//   grant_o [NREQ-1:0]  one-hot grant, all zero when no request
//   idx_o   [IDXW-1:0]  index of the granted bit (0 when none)
//   any_o               at least one request present
// ---------------------------------------------------------------------------
module fpu_rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDXW-1:0] idx_o,
  output logic            any_o
);

  always_comb begin : pick
    int  j;
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < NREQ; i++) begin
      // Candidate index (ptr + i) mod NREQ; ptr_i is always < NREQ so a
      // single subtraction is enough for the wrap.
      j = int'(ptr_i) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req_i[j[IDXW-1:0]]) begin
        found                   = 1'b1;
        idx_o                   = j[IDXW-1:0];
        grant_o[j[IDXW-1:0]]    = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/fpu_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_arbiter -- shares one FPU core between NREQ requester ports.
//
// One operation is in flight at a time. A request is accepted in IDLE
// (round-robin among the valid ports), issued to the core for one cycle,
// waited on until the core drops fpu_busy (or the busy counter reaches
// TIMEOUT), then answered with a one-cycle pulse on the originating port.
//
// Handshake: a request transfers on the cycle where req_valid[i] &
// req_ready[i] are both high at the clock edge. req_ready is only ever high
// for a port whose req_valid is high, for at most one port, and only in
// IDLE. The requester must hold op/a/b stable while valid and not ready.
// rsp_valid is a pulse with no back-pressure; rsp_result and rsp_error are
// meaningful only while a rsp_valid bit is high (both read 0 otherwise).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/op/a/b [NREQ]  per-port request
//   req_ready [NREQ]         one-hot accept strobe
//   rsp_valid [NREQ]         one-hot completion pulse
//   rsp_result, rsp_error    completion data; error = timeout abort
//   fpu_start/op/a/b         drive to the shared core
//   fpu_busy, fpu_result     from the shared core
//   dbg_state                current FSM state
// ---------------------------------------------------------------------------
module fpu_arbiter
  import fpu_p::*;
#(
  parameter int WIDTH   = FPU_32,
  parameter int NREQ    = FPU_ARB_NREQ,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,

  input  logic [NREQ-1:0]     req_valid,
  input  Operation            req_op [NREQ],
  input  logic [WIDTH-1:0]    req_a  [NREQ],
  input  logic [WIDTH-1:0]    req_b  [NREQ],
  output logic [NREQ-1:0]     req_ready,

  output logic [NREQ-1:0]     rsp_valid,
  output logic [WIDTH-1:0]    rsp_result,
  output logic                rsp_error,

  output logic                fpu_start,
  output Operation            fpu_op,
  output logic [WIDTH-1:0]    fpu_a,
  output logic [WIDTH-1:0]    fpu_b,
  input  logic                fpu_busy,
  input  logic [WIDTH-1:0]    fpu_result,

  output ArbState             dbg_state
);

  localparam int IDXW = $clog2(NREQ);
  localparam int CNTW = arb_cnt_width(TIMEOUT);

  ArbState          state_q;
  logic [IDXW-1:0]  ptr_q;      // round-robin search start
  logic [IDXW-1:0]  port_q;     // port owning the in-flight operation
  Operation         op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic             err_q;
  logic [CNTW-1:0]  cnt_q;      // cycles spent in WAIT

  logic [NREQ-1:0]  win_grant;
  logic [IDXW-1:0]  win_idx;
  logic             win_any;
  logic [IDXW-1:0]  ptr_next;

  fpu_rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (win_grant),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  // Next search starts just after the winner, wrapping at NREQ.
  assign ptr_next = (win_idx == IDXW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

  // ---------------------------------------------------------------------
  // Control FSM and operation registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      port_q   <= '0;
      op_q     <= ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_any) begin
            port_q  <= win_idx;
            op_q    <= req_op[win_idx];
            a_q     <= req_a[win_idx];
            b_q     <= req_b[win_idx];
            ptr_q   <= ptr_next;
            state_q <= ISSUE;
          end
        end

        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end

        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          // The core may not have raised fpu_busy yet in the first WAIT
          // cycle (cnt_q == 0), so its busy flag is only trusted afterwards.
          if ((cnt_q != '0) && !fpu_busy) begin
            result_q <= fpu_result;
            err_q    <= 1'b0;
            state_q  <= RESP;
          end else if (cnt_q == CNTW'(TIMEOUT)) begin
            result_q <= '0;
            err_q    <= 1'b1;
            state_q  <= RESP;
          end
        end

        RESP: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign req_ready = (state_q == IDLE) ? win_grant : '0;

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[port_q] = 1'b1;
  end

  assign rsp_result = (state_q == RESP) ? result_q : '0;
  assign rsp_error  = (state_q == RESP) && err_q;

  assign fpu_start  = (state_q == ISSUE);
  assign fpu_op     = op_q;
  assign fpu_a      = a_q;
  assign fpu_b      = b_q;

  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
module tb_fpu_arbiter;
  import fpu_p::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 255;

  // -------------------------------------------------------------------
  // Clock / reset and DUT
  // -------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0] req_valid;
  Operation     req_op [N];
  logic [W-1:0] req_a  [N];
  logic [W-1:0] req_b  [N];
  logic [N-1:0] req_ready;
  logic [N-1:0] rsp_valid;
  logic [W-1:0] rsp_result;
  logic         rsp_error;
  logic         fpu_start;
  Operation     fpu_op;
  logic [W-1:0] fpu_a;
  logic [W-1:0] fpu_b;
  logic         fpu_busy;
  logic [W-1:0] fpu_result;
  ArbState      dbg_state;

  fpu_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_error  (rsp_error),
    .fpu_start  (fpu_start),
    .fpu_op     (fpu_op),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_busy   (fpu_busy),
    .fpu_result (fpu_result),
    .dbg_state  (dbg_state)
  );

  // -------------------------------------------------------------------
  // Shared state
  // -------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  int rsp_seen = 0;
  logic last_err;
  logic [N-1:0] acc_last;
  int core_lat_min;
  int core_lat_max;

  logic [W-1:0] exp_q[$];        // expected results, directed tests
  int           exp_port_q[$];   // expected responding port
  int           exp_grant_q[$];  // expected grant order

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Core behaviour: integer arithmetic except for the float vectors used by
  // the directed tests, for which it returns the IEEE-754 results.
  function automatic logic [W-1:0] core_fn(input Operation op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    if (op == ADD && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (op == MUL && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (op == SUB && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      default: return a * b;
    endcase
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int start);
    for (int i = 0; i < N; i++)
      if (v[(start + i) % N]) return (start + i) % N;
    return -1;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  // -------------------------------------------------------------------
  // Core model + reference model + per-cycle compare
  // Inputs change at negedge; everything is sampled 1 time unit later,
  // i.e. the values the next posedge will see.
  // -------------------------------------------------------------------
  initial begin : monitor
    int       m_mode;   // 0 idle, 1 operation in flight, 2 responding
    int       m_e;      // cycles since grant
    int       m_ptr, m_port, w;
    Operation m_op, m_fop;
    logic [W-1:0] m_a, m_b, m_res, m_fa, m_fb;
    logic     m_err;
    int       c_left;
    logic [W-1:0] c_res, s_a, s_b;
    Operation s_op;
    logic     start_seen;
    logic [N-1:0] e_ready, e_rsp;
    logic     e_start, e_err;
    ArbState  e_st;

    m_mode = 0; m_e = 0; m_ptr = 0; m_port = 0; w = -1;
    m_op = ADD; m_fop = ADD; m_a = '0; m_b = '0; m_res = '0; m_fa = '0; m_fb = '0;
    m_err = 1'b0; c_left = 0; c_res = '0; s_a = '0; s_b = '0; s_op = ADD;
    start_seen = 1'b0; acc_last = '0; last_err = 1'b0; e_st = IDLE;
    fpu_busy = 1'b0; fpu_result = '0;

    forever begin
      @(negedge clk);
      if (start_seen) begin
        c_left = $urandom_range(core_lat_max, core_lat_min);
        c_res  = core_fn(s_op, s_a, s_b);
      end
      fpu_busy   = (c_left > 0);
      fpu_result = c_res;
      if (c_left > 0) c_left--;
      #1;
      start_seen = !rst && fpu_start;
      s_op = fpu_op; s_a = fpu_a; s_b = fpu_b;

      if (rst) begin
        m_mode = 0; m_ptr = 0; m_e = 0;
        m_fop = ADD; m_fa = '0; m_fb = '0;
        acc_last = '0;
      end else begin
        e_ready = '0; e_rsp = '0; e_start = 1'b0; e_err = 1'b0; w = -1;
        case (m_mode)
          0: begin
            e_st = IDLE;
            w = rr_pick(req_valid, m_ptr);
            if (w >= 0) begin
              e_ready[w] = 1'b1;
              m_port = w; m_op = req_op[w]; m_a = req_a[w]; m_b = req_b[w];
              m_ptr = (w + 1) % N;
            end
          end
          1: begin
            m_e++;
            if (m_e == 1) begin
              e_st = ISSUE; e_start = 1'b1;
              m_fop = m_op; m_fa = m_a; m_fb = m_b;
            end else begin
              e_st = WAIT;
            end
          end
          default: begin
            e_st = RESP; e_rsp[m_port] = 1'b1; e_err = m_err;
          end
        endcase

        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
        chk("rsp_error", 32'(rsp_error), 32'(e_err));
        if (m_mode == 2) chk("rsp_result", rsp_result, m_res);
        chk("fpu_start", 32'(fpu_start), 32'(e_start));
        chk("fpu_op", 32'(fpu_op), 32'(m_fop));
        chk("fpu_a", fpu_a, m_fa);
        chk("fpu_b", fpu_b, m_fb);
        chk("state", 32'(dbg_state), 32'(e_st));

        acc_last = req_valid & req_ready;
        if (req_ready != '0 && exp_grant_q.size() > 0)
          chk("sb_grant", oh_idx(req_ready), exp_grant_q.pop_front());
        if (rsp_valid != '0) begin
          rsp_seen++;
          last_err = rsp_error;
          if (exp_q.size() > 0) begin
            chk("sb_result", rsp_result, exp_q.pop_front());
            chk("sb_port", oh_idx(rsp_valid), exp_port_q.pop_front());
          end
        end

        case (m_mode)
          0: if (w >= 0) begin m_mode = 1; m_e = 0; end
          1: begin
            if (m_e >= 3 && !fpu_busy) begin
              m_mode = 2; m_res = core_fn(m_op, m_a, m_b); m_err = 1'b0;
            end else if (m_e == TO + 2) begin
              m_mode = 2; m_res = '0; m_err = 1'b1;
            end
          end
          default: m_mode = 0;
        endcase
      end
    end
  end

  // -------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_accept(input int p);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (acc_last[p]) begin
        ok = 1'b1;
        req_valid[p] = 1'b0;
        req_a[p] = $urandom;   // post-grant changes must not matter
        req_b[p] = $urandom;
        break;
      end
    end
    chk("accept_in_time", 32'(ok), 32'd1);
  endtask

  task automatic issue(input int p, input Operation op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    @(negedge clk);
    req_valid[p] = 1'b1; req_op[p] = op; req_a[p] = a; req_b[p] = b;
    wait_accept(p);
  endtask

  task automatic wait_rsp(input int target, input int budget, input string name);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (rsp_seen >= target) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic set_rand_req(input int p);
    req_op[p] = Operation'($urandom_range(0, 2));
    req_a[p]  = $urandom;
    req_b[p]  = $urandom;
  endtask

  // -------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------
  initial begin : main
    int base;
    logic [N-1:0] got;

    req_valid = '0;
    for (int p = 0; p < N; p++) begin
      req_op[p] = ADD; req_a[p] = '0; req_b[p] = '0;
    end
    core_lat_min = 1; core_lat_max = 4;

    // Reset values
    do_reset(3);
    #2;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_fpu_start", 32'(fpu_start), 32'd0);
    chk("rst_fpu_op", 32'(fpu_op), 32'(ADD));
    chk("rst_fpu_a", fpu_a, 32'd0);
    chk("rst_fpu_b", fpu_b, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));

    // Single ADD on port 0
    base = rsp_seen;
    exp_grant_q.push_back(0);
    exp_q.push_back(32'h40400000); exp_port_q.push_back(0);
    issue(0, ADD, 32'h3F800000, 32'h40000000);
    wait_rsp(base + 1, 50, "t1_rsp_in_time");
    chk("t1_err", 32'(last_err), 32'd0);
    repeat (10) @(negedge clk);
    chk("t1_single_pulse", rsp_seen - base, 1);
    chk("t1_sb_empty", exp_q.size() + exp_grant_q.size(), 0);

    // All four ports request MUL together
    do_reset(2);
    base = rsp_seen; got = '0;
    for (int p = 0; p < N; p++) begin
      exp_grant_q.push_back(p);
      exp_q.push_back(32'h40C00000); exp_port_q.push_back(p);
    end
    @(negedge clk);
    for (int p = 0; p < N; p++) begin
      req_valid[p] = 1'b1; req_op[p] = MUL; req_a[p] = 32'h40000000; req_b[p] = 32'h40400000;
    end
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      for (int p = 0; p < N; p++)
        if (acc_last[p]) begin req_valid[p] = 1'b0; got[p] = 1'b1; end
      if (got == '1 && rsp_seen >= base + 4) break;
    end
    chk("t2_all_granted", 32'(got), 32'hF);
    chk("t2_rsp_count", rsp_seen - base, 4);
    chk("t2_sb_empty", exp_q.size() + exp_grant_q.size(), 0);

    // Port 2 SUB, port 1 requests while it is in flight
    do_reset(2);
    base = rsp_seen;
    exp_grant_q.push_back(2); exp_grant_q.push_back(1);
    exp_q.push_back(32'h40000000); exp_port_q.push_back(2);
    exp_q.push_back(32'h40C00000); exp_port_q.push_back(1);
    issue(2, SUB, 32'h40400000, 32'h3F800000);
    req_valid[1] = 1'b1; req_op[1] = MUL; req_a[1] = 32'h40000000; req_b[1] = 32'h40400000;
    wait_accept(1);
    wait_rsp(base + 2, 50, "t3_rsp_in_time");
    chk("t3_sb_empty", exp_q.size() + exp_grant_q.size(), 0);

    // Core stuck busy for 300 cycles -> timeout abort
    core_lat_min = 300; core_lat_max = 300;
    base = rsp_seen;
    exp_grant_q.push_back(3);
    exp_q.push_back(32'h0); exp_port_q.push_back(3);
    issue(3, ADD, 32'h1, 32'h2);
    wait_rsp(base + 1, 400, "t4_rsp_in_time");
    chk("t4_err", 32'(last_err), 32'd1);
    #2;
    chk("t4_back_idle", 32'(dbg_state), 32'(IDLE));
    chk("t4_sb_empty", exp_q.size() + exp_grant_q.size(), 0);

    // Reset during WAIT
    core_lat_min = 20; core_lat_max = 20;
    do_reset(2);
    issue(2, ADD, 32'h10, 32'h20);
    for (int k = 0; k < 10; k++) begin
      #2;
      if (dbg_state == WAIT) break;
      @(negedge clk);
    end
    chk("t5_in_wait", 32'(dbg_state), 32'(WAIT));
    base = rsp_seen;
    do_reset(1);
    repeat (30) @(negedge clk);
    chk("t5_no_rsp", rsp_seen - base, 0);
    core_lat_min = 1; core_lat_max = 4;
    exp_grant_q.push_back(0);
    got = '0;
    for (int p = 0; p < N; p++) begin
      req_valid[p] = 1'b1; set_rand_req(p);
    end
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      for (int p = 0; p < N; p++)
        if (acc_last[p]) begin req_valid[p] = 1'b0; got[p] = 1'b1; end
      if (got == '1) break;
    end
    chk("t5_all_granted", 32'(got), 32'hF);
    chk("t5_sb_empty", exp_grant_q.size(), 0);

    // Randomized traffic
    core_lat_min = 0; core_lat_max = 6;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      for (int p = 0; p < N; p++) begin
        if (req_valid[p] && acc_last[p]) begin
          req_valid[p] = ($urandom_range(0, 3) == 0);
          set_rand_req(p);
        end else if (!req_valid[p]) begin
          if ($urandom_range(0, 5) == 0) begin
            req_valid[p] = 1'b1; set_rand_req(p);
          end
        end else if ($urandom_range(0, 40) == 0) begin
          req_valid[p] = 1'b0;
        end
      end
    end
    req_valid = '0;
    repeat (30) @(negedge clk);
    #2;
    chk("final_idle", 32'(dbg_state), 32'(IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 Parameter WIDTH, default fpu_p::FPU_32, operand/result width passed to the shared FPU core.
REQ-002 Parameter NREQ, default 4, number of requester ports (2..8).
REQ-003 Parameter TIMEOUT, default 255, maximum core busy cycles before abort.
REQ-004 clk  input  1  clock; all logic on posedge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  NREQ  per-port operation request.
REQ-007 req_op  input  NREQ x fpu_p::Operation  per-port operation (ADD/SUB/MUL).
REQ-008 req_a, req_b  input  NREQ x WIDTH  per-port operands.
REQ-009 req_ready  output  NREQ  one-hot accept strobe; transfer when req_valid & req_ready.
REQ-010 rsp_valid  output  NREQ  one-hot, one-cycle completion pulse to the originating port.
REQ-011 rsp_result  output  WIDTH  result, valid only while any rsp_valid bit is high.
REQ-012 rsp_error  output  1  qualifies rsp_valid; high = timeout abort, rsp_result = 0.
REQ-013 fpu_start, fpu_op, fpu_a, fpu_b  output  1/Operation/WIDTH/WIDTH  drive to shared core.
REQ-014 fpu_busy, fpu_result  input  1/WIDTH  from shared core.

Function
REQ-015 FSM states IDLE, ISSUE, WAIT, RESP; exactly one operation in flight at any time.
REQ-016 IDLE: if any req_valid, grant the round-robin winner: assert its req_ready for one cycle, latch port index, op, a, b; go to ISSUE.
REQ-017 Round-robin: search starts at (last granted index + 1) mod NREQ; pointer updates only on grant; after reset, search starts at port 0.
REQ-018 req_ready is combinational from state==IDLE and the arbiter winner; never high outside IDLE; at most one bit high.
REQ-019 ISSUE: fpu_start=1 for exactly one cycle with latched op/a/b; go to WAIT.
REQ-020 fpu_op/fpu_a/fpu_b hold latched values from ISSUE through WAIT.
REQ-021 WAIT: ignore fpu_busy in the first WAIT cycle; thereafter, on fpu_busy==0, capture fpu_result into the result register and go to RESP.
REQ-022 WAIT: an 8-bit-minimum cycle counter increments each cycle; on reaching TIMEOUT with fpu_busy still high, go to RESP with error flag set.
REQ-023 RESP: assert rsp_valid[latched port] for one cycle with rsp_result/rsp_error; go to IDLE.
REQ-024 Minimum latency req accept -> rsp_valid = core latency + 3 cycles; back-to-back grants separated by no less than 1 IDLE cycle.
REQ-025 A port deasserting req_valid before grant loses nothing; requests changing after grant do not affect the in-flight operation.
REQ-026 A port may re-request during its own WAIT/RESP; it is arbitrated normally in the next IDLE.
REQ-027 SUB is forwarded unmodified as op SUB; the arbiter does not alter operand signs.

Reset
REQ-028 On rst: state IDLE, rr pointer so port 0 wins first, counter 0, result/error registers 0.
REQ-029 Outputs during/after reset: req_ready per REQ-018, rsp_valid 0, rsp_error 0, rsp_result 0, fpu_start 0, fpu_op ADD, fpu_a/fpu_b 0.
REQ-030 rst asserted mid-operation aborts silently: no rsp_valid issued for the in-flight request.

Structure
REQ-031 fpu_p package gains typedef ArbState (IDLE, ISSUE, WAIT, RESP) and constant FPU_ARB_NREQ=4; Operation reused from fpu_p.
REQ-032 One sub-module fpu_rr_arbiter: combinational NREQ-bit round-robin picker (request vector, pointer -> one-hot grant, index).

Verification
REQ-033 Port 0 ADD a=32'h3F800000 b=32'h40000000 -> rsp_valid[0] single pulse, rsp_result 32'h40400000, rsp_error 0.
REQ-034 Ports 0..3 all valid MUL 32'h40000000*32'h40400000 held -> grants in order 0,1,2,3, each rsp_result 32'h40C00000, one in flight at a time.
REQ-035 Port 2 SUB 32'h40400000-32'h3F800000 while port 1 re-requests -> port 2 result 32'h40000000, port 1 next grant after port 2 rsp.
REQ-036 Core model holding fpu_busy=1 for 300 cycles, TIMEOUT=255 -> rsp_valid with rsp_error=1, rsp_result 0, arbiter returns to IDLE.
REQ-037 rst asserted in WAIT -> no rsp_valid, fpu_start 0, next request granted to port 0 first.
